// File: rtl/gfx_write_scheduler.sv
// In-order command buffer between the execute stage and the VGA write ports.
// Commands are released only while the blanking window their target needs is open.
module gfx_write_scheduler #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_type,
    input  logic [4:0]    cmd_sel,
    input  logic [10:0]   cmd_a,
    input  logic [8:0]    cmd_b,
    input  logic          cmd_vis,
    input  logic          vblank,
    input  logic          hblank,
    output logic          stall,
    output logic          spr_pos_we,
    output logic          spr_attr_we,
    output logic [4:0]    spr_sel,
    output logic [9:0]    spr_x,
    output logic [8:0]    spr_y,
    output logic          spr_vis,
    output logic          spr_attr,
    output logic          font_we,
    output logic [10:0]   font_addr,
    output logic [3:0]    font_data,
    output logic          bck_we,
    output logic [1:0]    bck,
    output logic [AW:0]   fill,
    output logic [1:0]    dbg_state
);

    localparam int EW = 28;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    localparam logic [1:0] T_POS  = 2'b00;
    localparam logic [1:0] T_ATTR = 2'b01;
    localparam logic [1:0] T_FONT = 2'b10;
    localparam logic [1:0] T_BCK  = 2'b11;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     fill_q, fill_d;

    logic            spr_pos_we_q, spr_attr_we_q, font_we_q, bck_we_q;
    logic [4:0]      spr_sel_q;
    logic [9:0]      spr_x_q;
    logic [8:0]      spr_y_q;
    logic            spr_vis_q, spr_attr_q;
    logic [10:0]     font_addr_q;
    logic [3:0]      font_data_q;
    logic [1:0]      bck_q;

    logic [EW-1:0]   head_w;
    logic [1:0]      head_type;
    logic [4:0]      head_sel;
    logic [10:0]     head_a;
    logic [8:0]      head_b;
    logic            head_vis;
    logic            head_ok;
    logic            push;
    logic            pop;
    logic            last_pop;

    // Handshake: a command transfers on any cycle with cmd_valid=1 and stall=0.
    // While stall=1 the source keeps cmd_* stable and cmd_valid high; nothing is taken.
    assign stall    = (fill_q == FULL);
    assign push     = cmd_valid && !stall;

    assign head_w    = mem_q[rd_ptr_q];
    assign head_type = head_w[27:26];
    assign head_sel  = head_w[25:21];
    assign head_a    = head_w[20:10];
    assign head_b    = head_w[9:1];
    assign head_vis  = head_w[0];

    // Font RAM is only read during active pixels, so hblank is enough for it;
    // sprite table and background are latched per frame and need vblank.
    assign head_ok  = (head_type == T_FONT) ? (vblank || hblank) : vblank;
    assign pop      = (fill_q != '0) && head_ok;
    assign last_pop = pop && (fill_q == ONE) && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_type, cmd_sel, cmd_a, cmd_b, cmd_vis};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + ONE;
            2'b01:   fill_d = fill_q - ONE;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Sequencer state plus the registered write ports; data fields are only
    // touched by the command type that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_EMPTY;
            spr_pos_we_q  <= 1'b0;
            spr_attr_we_q <= 1'b0;
            font_we_q     <= 1'b0;
            bck_we_q      <= 1'b0;
            spr_sel_q     <= '0;
            spr_x_q       <= '0;
            spr_y_q       <= '0;
            spr_vis_q     <= 1'b0;
            spr_attr_q    <= 1'b0;
            font_addr_q   <= '0;
            font_data_q   <= '0;
            bck_q         <= '0;
        end else begin
            spr_pos_we_q  <= 1'b0;
            spr_attr_we_q <= 1'b0;
            font_we_q     <= 1'b0;
            bck_we_q      <= 1'b0;

            if (pop) begin
                case (head_type)
                    T_POS: begin
                        spr_pos_we_q <= 1'b1;
                        spr_sel_q    <= head_sel;
                        spr_x_q      <= head_a[9:0];
                        spr_y_q      <= head_b;
                        spr_vis_q    <= head_vis;
                    end
                    T_ATTR: begin
                        spr_attr_we_q <= 1'b1;
                        spr_sel_q     <= head_sel;
                        spr_attr_q    <= head_b[0];
                    end
                    T_FONT: begin
                        font_we_q   <= 1'b1;
                        font_addr_q <= head_a;
                        font_data_q <= head_b[3:0];
                    end
                    T_BCK: begin
                        bck_we_q <= 1'b1;
                        bck_q    <= head_a[1:0];
                    end
                    default: ;
                endcase
            end

            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pop) begin
                        state_q <= last_pop ? S_EMPTY : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state_q <= S_EMPTY;
                    end else if (!pop) begin
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    assign spr_pos_we  = spr_pos_we_q;
    assign spr_attr_we = spr_attr_we_q;
    assign spr_sel     = spr_sel_q;
    assign spr_x       = spr_x_q;
    assign spr_y       = spr_y_q;
    assign spr_vis     = spr_vis_q;
    assign spr_attr    = spr_attr_q;
    assign font_we     = font_we_q;
    assign font_addr   = font_addr_q;
    assign font_data   = font_data_q;
    assign bck_we      = bck_we_q;
    assign bck         = bck_q;
    assign fill        = fill_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_gfx_write_scheduler.sv
// Directed bench for gfx_write_scheduler: expected write-port transactions are
// queued as commands are accepted and matched in order by an output monitor.
module tb_gfx_write_scheduler;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [1:0]    cmd_type;
    logic [4:0]    cmd_sel;
    logic [10:0]   cmd_a;
    logic [8:0]    cmd_b;
    logic          cmd_vis;
    logic          vblank;
    logic          hblank;
    logic          stall;
    logic          spr_pos_we;
    logic          spr_attr_we;
    logic [4:0]    spr_sel;
    logic [9:0]    spr_x;
    logic [8:0]    spr_y;
    logic          spr_vis;
    logic          spr_attr;
    logic          font_we;
    logic [10:0]   font_addr;
    logic [3:0]    font_data;
    logic          bck_we;
    logic [1:0]    bck;
    logic [AW:0]   fill;
    logic [1:0]    dbg_state;

    int            n_vec    = 0;
    int            n_err    = 0;
    int            font_cnt = 0;
    int            base;
    logic [31:0]   exp_q[$];

    int            mon_n;
    logic [31:0]   mon_act;
    logic [31:0]   mon_exp;

    gfx_write_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_type    (cmd_type),
        .cmd_sel     (cmd_sel),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_vis     (cmd_vis),
        .vblank      (vblank),
        .hblank      (hblank),
        .stall       (stall),
        .spr_pos_we  (spr_pos_we),
        .spr_attr_we (spr_attr_we),
        .spr_sel     (spr_sel),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_vis     (spr_vis),
        .spr_attr    (spr_attr),
        .font_we     (font_we),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .bck_we      (bck_we),
        .bck         (bck),
        .fill        (fill),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // transaction encodings: {kind, zero pad, fields}
    function automatic logic [31:0] exp_pos(input logic [4:0] sel, input logic [9:0] x,
                                            input logic [8:0] y, input logic vis);
        return {2'b00, 5'd0, sel, x, y, vis};
    endfunction

    function automatic logic [31:0] exp_attr(input logic [4:0] sel, input logic attr);
        return {2'b01, 24'd0, sel, attr};
    endfunction

    function automatic logic [31:0] exp_font(input logic [10:0] addr, input logic [3:0] data);
        return {2'b10, 15'd0, addr, data};
    endfunction

    function automatic logic [31:0] exp_bck(input logic [1:0] v);
        return {2'b11, 28'd0, v};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: hold the command until it is taken, then queue its expected transaction
    task automatic push_cmd(input logic [1:0] t, input logic [4:0] s, input logic [10:0] a,
                            input logic [8:0] b, input logic v, input logic [31:0] e);
        int  waited;
        bit  done;
        waited   = 0;
        done     = 1'b0;
        cmd_type = t;
        cmd_sel  = s;
        cmd_a    = a;
        cmd_b    = b;
        cmd_vis  = v;
        cmd_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (!stall) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else if (waited >= 200) begin
                n_vec++;
                n_err++;
                $display("FAIL push_timeout: got stall=1 for %0d cycles expected accept", waited);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic push_pos(input logic [4:0] sel, input logic [9:0] x, input logic [8:0] y,
                            input logic vis);
        push_cmd(2'b00, sel, {1'b1, x}, y, vis, exp_pos(sel, x, y, vis));
    endtask

    task automatic push_attr(input logic [4:0] sel, input logic attr);
        push_cmd(2'b01, sel, 11'h5A5, {8'hA5, attr}, 1'b1, exp_attr(sel, attr));
    endtask

    task automatic push_font(input logic [10:0] addr, input logic [3:0] data);
        push_cmd(2'b10, 5'h1F, addr, {5'h15, data}, 1'b1, exp_font(addr, data));
    endtask

    task automatic push_bck(input logic [1:0] v);
        push_cmd(2'b11, 5'h0A, {9'h155, v}, 9'h1AA, 1'b1, exp_bck(v));
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (fill == '0 && exp_q.size() == 0) ok = 1'b1;
        end
        check(name, 64'(ok), 64'd1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        mon_n = int'(spr_pos_we) + int'(spr_attr_we) + int'(font_we) + int'(bck_we);
        if (mon_n > 0) begin
            if (font_we) font_cnt++;
            n_vec++;
            if (mon_n > 1) begin
                n_err++;
                $display("FAIL multi_strobe: got %0d strobes expected 1", mon_n);
            end else begin
                if (spr_pos_we)       mon_act = exp_pos(spr_sel, spr_x, spr_y, spr_vis);
                else if (spr_attr_we) mon_act = exp_attr(spr_sel, spr_attr);
                else if (font_we)     mon_act = exp_font(font_addr, font_data);
                else                  mon_act = exp_bck(bck);
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe: got %0h expected none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_err++;
                        $display("FAIL strobe_data: got %0h expected %0h", mon_act, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = '0;
        cmd_sel   = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_vis   = 1'b0;
        vblank    = 1'b0;
        hblank    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: reset then idle
        repeat (2) tick();
        @(negedge clk);
        check("t1_outputs", 64'({spr_pos_we, spr_attr_we, spr_sel, spr_x, spr_y, spr_vis, spr_attr,
                                 font_we, font_addr, font_data, bck_we, bck}), 64'd0);
        check("t1_fill", 64'(fill), 64'd0);
        check("t1_stall", 64'(stall), 64'd0);
        check("t1_state", 64'(dbg_state), 64'd0);
        tick();

        // 2: minimum latency sprite pos, then a background write
        vblank    = 1'b1;
        cmd_type  = 2'b00;
        cmd_sel   = 5'd3;
        cmd_a     = {1'b1, 10'd200};
        cmd_b     = 9'd150;
        cmd_vis   = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("t2_c0_stall", 64'(stall), 64'd0);
        exp_q.push_back(exp_pos(5'd3, 10'd200, 9'd150, 1'b1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t2_c1_no_strobe", 64'(spr_pos_we), 64'd0);
        check("t2_c1_fill", 64'(fill), 64'd1);
        @(negedge clk);
        check("t2_c2_strobe", 64'(spr_pos_we), 64'd1);
        check("t2_c2_fields", 64'({spr_sel, spr_x, spr_y, spr_vis}),
              64'({5'd3, 10'd200, 9'd150, 1'b1}));
        check("t2_c2_fill", 64'(fill), 64'd0);
        tick();
        push_bck(2'b10);
        wait_drain("t2_bck_drain", 20);
        check("t2_bck_value", 64'(bck), 64'd2);
        tick();
        vblank = 1'b0;

        // 3: fill with no window, then a 3-cycle hblank
        base = font_cnt;
        for (int i = 0; i < 8; i++) begin
            push_font(11'h7F0 + 11'(i), 4'(i * 3 + 1));
        end
        @(negedge clk);
        check("t3_stall_full", 64'(stall), 64'd1);
        check("t3_fill_full", 64'(fill), 64'd8);
        check("t3_no_strobe", 64'(font_cnt - base), 64'd0);
        tick();
        hblank = 1'b1;
        repeat (3) tick();
        hblank = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("t3_three_pulses", 64'(font_cnt - base), 64'd3);
        check("t3_fill_after", 64'(fill), 64'd5);
        check("t3_stall_after", 64'(stall), 64'd0);
        check("t3_pending", 64'(exp_q.size()), 64'd5);
        tick();
        hblank = 1'b1;
        wait_drain("t3_drain", 40);
        tick();
        hblank = 1'b0;

        // 4: sprite attr at the head blocks a younger font write
        hblank = 1'b1;
        base = font_cnt;
        push_font(11'h012, 4'hC);
        push_attr(5'd7, 1'b1);
        push_font(11'h013, 4'h3);
        repeat (4) tick();
        @(negedge clk);
        check("t4_first_font", 64'(font_cnt - base), 64'd1);
        check("t4_fill_blocked", 64'(fill), 64'd2);
        check("t4_pending", 64'(exp_q.size()), 64'd2);
        check("t4_state_wait", 64'(dbg_state), 64'd1);
        tick();
        vblank = 1'b1;
        wait_drain("t4_drain", 20);
        check("t4_second_font", 64'(font_cnt - base), 64'd2);
        check("t4_attr_fields", 64'({spr_sel, spr_attr}), 64'({5'd7, 1'b1}));
        check("t4_pos_held", 64'({spr_x, spr_y, spr_vis}), 64'({10'd200, 9'd150, 1'b1}));
        tick();
        vblank = 1'b0;
        hblank = 1'b0;

        // 5: full FIFO, window opens, source keeps pushing
        for (int i = 0; i < 8; i++) begin
            push_pos(5'(i), 10'(i * 37 + 5), 9'(i * 19 + 2), 1'(i % 2));
        end
        @(negedge clk);
        check("t5_stall_full", 64'(stall), 64'd1);
        tick();
        vblank = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_pos(5'(8 + i), 10'(500 + i), 9'(300 + i), 1'b1);
            check("t5_fill_steady", 64'(fill), 64'd7);
        end
        wait_drain("t5_drain", 40);
        tick();
        vblank = 1'b0;

        // 6: reset while draining
        for (int i = 0; i < 8; i++) begin
            push_pos(5'(16 + i), 10'(700 + i * 11), 9'(400 + i * 7), 1'b1);
        end
        vblank = 1'b1;
        repeat (3) tick();
        check("t6_fill_mid", 64'(fill), 64'd5);
        check("t6_state_drain", 64'(dbg_state), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_fill_reset", 64'(fill), 64'd0);
        check("t6_outputs_reset", 64'({spr_pos_we, spr_attr_we, spr_sel, spr_x, spr_y, spr_vis,
                                       spr_attr, font_we, font_addr, font_data, bck_we, bck}), 64'd0);
        check("t6_stall_reset", 64'(stall), 64'd0);
        check("t6_state_reset", 64'(dbg_state), 64'd0);
        tick();
        push_font(11'h3AB, 4'h9);
        push_pos(5'd30, 10'd1023, 9'd511, 1'b0);
        wait_drain("t6_after_reset", 20);
        tick();
        vblank = 1'b0;

        repeat (3) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
